// File: rtl/obstacle_spawn_timer.sv
// Programmable wait timer feeding obstacle_generator. A start loads a wait of
// time_to_wait_in ticks, each tick being TICK_CYCLES clocks; expired_out pulses
// for one cycle when the wait completes. Supports pause and restart-on-start.
module obstacle_spawn_timer #(
    parameter int unsigned TICK_CYCLES = 16_250_000,
    parameter int unsigned PRE_W       = 24
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       start_timer_in,
    input  logic [3:0] time_to_wait_in,
    input  logic       pause_in,
    output logic       expired_out,
    output logic       busy_out,
    output logic [3:0] remaining_out
);

    typedef enum logic [0:0] {StIdle, StCount} state_e;

    localparam logic [PRE_W-1:0] PreLast = PRE_W'(TICK_CYCLES - 1);
    localparam logic [PRE_W-1:0] PreOne  = PRE_W'(1);

    state_e           state_q, state_d;
    logic [PRE_W-1:0] prescaler_q, prescaler_d;
    logic [3:0]       remaining_q, remaining_d;
    logic             expired_q, expired_d;

    // Next-state: start beats pause, pause beats counting.
    always_comb begin
        state_d     = state_q;
        prescaler_d = prescaler_q;
        remaining_d = remaining_q;
        expired_d   = 1'b0;
        if (start_timer_in) begin
            if (time_to_wait_in != 4'd0) begin
                remaining_d = time_to_wait_in;
                prescaler_d = '0;
                state_d     = StCount;
            end else begin
                // Zero-length wait expires immediately.
                remaining_d = 4'd0;
                state_d     = StIdle;
                expired_d   = 1'b1;
            end
        end else if (state_q == StCount && !pause_in) begin
            if (prescaler_q != PreLast) begin
                prescaler_d = prescaler_q + PreOne;
            end else begin
                prescaler_d = '0;
                remaining_d = remaining_q - 4'd1;
                if (remaining_q == 4'd1) begin
                    state_d   = StIdle;
                    expired_d = 1'b1;
                end
            end
        end
    end

    // State and registered outputs; reset discards any in-flight wait.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= StIdle;
            prescaler_q <= '0;
            remaining_q <= 4'd0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prescaler_q <= prescaler_d;
            remaining_q <= remaining_d;
            expired_q   <= expired_d;
        end
    end

    assign expired_out   = expired_q;
    assign busy_out      = (state_q == StCount);
    assign remaining_out = remaining_q;

endmodule

// File: tb/tb_obstacle_spawn_timer.sv
// Directed bench for obstacle_spawn_timer with TICK_CYCLES=4. Each scenario
// releases reset so that cycle 0 begins, then walks cycle by cycle.
module tb_obstacle_spawn_timer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] tw;
    logic       pause;
    logic       expired;
    logic       busy;
    logic [3:0] rem;

    int n_checks = 0;
    int n_pass   = 0;

    obstacle_spawn_timer #(
        .TICK_CYCLES(4),
        .PRE_W      (3)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .start_timer_in (start),
        .time_to_wait_in(tw),
        .pause_in       (pause),
        .expired_out    (expired),
        .busy_out       (busy),
        .remaining_out  (rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset, then release at the start of cycle 0 (1 time unit after an edge).
    task automatic begin_scenario();
        rst_n = 1'b0;
        start = 1'b0;
        tw    = 4'd0;
        pause = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b1;
        tw    = 4'd7;
        pause = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (expired !== 1'b0) $display("FAIL reset_expired got=%b want=0", expired);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy);
        else n_pass++;
        n_checks++;
        if (rem !== 4'd0) $display("FAIL reset_remaining got=%0d want=0", rem);
        else n_pass++;
    endtask

    task automatic test_basic_w3();
        logic e_exp, e_busy;
        logic [3:0] e_rem;
        begin_scenario();
        for (int c = 0; c <= 30; c++) begin
            start = (c == 10);
            tw    = (c == 10) ? 4'd3 : 4'd0;
            #1;
            e_exp  = (c == 23);
            e_busy = (c >= 11 && c <= 22);
            e_rem  = (c >= 11 && c <= 14) ? 4'd3 : (c >= 15 && c <= 18) ? 4'd2 :
                     (c >= 19 && c <= 22) ? 4'd1 : 4'd0;
            n_checks++;
            if (expired !== e_exp) $display("FAIL w3_expired c=%0d got=%b want=%b", c, expired, e_exp);
            else n_pass++;
            n_checks++;
            if (busy !== e_busy) $display("FAIL w3_busy c=%0d got=%b want=%b", c, busy, e_busy);
            else n_pass++;
            n_checks++;
            if (rem !== e_rem) $display("FAIL w3_remaining c=%0d got=%0d want=%0d", c, rem, e_rem);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_zero_wait();
        logic e_exp;
        begin_scenario();
        for (int c = 0; c <= 20; c++) begin
            start = (c == 10);
            tw    = 4'd0;
            #1;
            e_exp = (c == 11);
            n_checks++;
            if (expired !== e_exp) $display("FAIL w0_expired c=%0d got=%b want=%b", c, expired, e_exp);
            else n_pass++;
            n_checks++;
            if (busy !== 1'b0) $display("FAIL w0_busy c=%0d got=%b want=0", c, busy);
            else n_pass++;
            n_checks++;
            if (rem !== 4'd0) $display("FAIL w0_remaining c=%0d got=%0d want=0", c, rem);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_pause();
        logic e_exp, e_busy;
        logic [3:0] e_rem;
        begin_scenario();
        for (int c = 0; c <= 30; c++) begin
            start = (c == 10);
            tw    = (c == 10) ? 4'd2 : 4'd0;
            pause = (c >= 12 && c <= 16);
            #1;
            e_exp  = (c == 24);
            e_busy = (c >= 11 && c <= 23);
            e_rem  = (c >= 11 && c <= 19) ? 4'd2 : (c >= 20 && c <= 23) ? 4'd1 : 4'd0;
            n_checks++;
            if (expired !== e_exp) $display("FAIL pause_expired c=%0d got=%b want=%b", c, expired, e_exp);
            else n_pass++;
            n_checks++;
            if (busy !== e_busy) $display("FAIL pause_busy c=%0d got=%b want=%b", c, busy, e_busy);
            else n_pass++;
            n_checks++;
            if (rem !== e_rem) $display("FAIL pause_remaining c=%0d got=%0d want=%0d", c, rem, e_rem);
            else n_pass++;
            next_cycle();
        end
        pause = 1'b0;
    endtask

    task automatic test_restart();
        logic e_exp, e_busy;
        logic [3:0] e_rem;
        begin_scenario();
        for (int c = 0; c <= 30; c++) begin
            start = (c == 10 || c == 14);
            tw    = (c == 10) ? 4'd4 : (c == 14) ? 4'd1 : 4'd0;
            #1;
            e_exp  = (c == 19);
            e_busy = (c >= 11 && c <= 18);
            e_rem  = (c >= 11 && c <= 14) ? 4'd4 : (c >= 15 && c <= 18) ? 4'd1 : 4'd0;
            n_checks++;
            if (expired !== e_exp) $display("FAIL restart_expired c=%0d got=%b want=%b", c, expired, e_exp);
            else n_pass++;
            n_checks++;
            if (busy !== e_busy) $display("FAIL restart_busy c=%0d got=%b want=%b", c, busy, e_busy);
            else n_pass++;
            n_checks++;
            if (rem !== e_rem) $display("FAIL restart_remaining c=%0d got=%0d want=%0d", c, rem, e_rem);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_start_at_terminal();
        logic e_exp, e_busy;
        logic [3:0] e_rem;
        begin_scenario();
        for (int c = 0; c <= 30; c++) begin
            start = (c == 10 || c == 14);
            tw    = (c == 10) ? 4'd1 : (c == 14) ? 4'd2 : 4'd0;
            #1;
            e_exp  = (c == 23);
            e_busy = (c >= 11 && c <= 22);
            e_rem  = (c >= 11 && c <= 14) ? 4'd1 : (c >= 15 && c <= 18) ? 4'd2 :
                     (c >= 19 && c <= 22) ? 4'd1 : 4'd0;
            n_checks++;
            if (expired !== e_exp) $display("FAIL term_expired c=%0d got=%b want=%b", c, expired, e_exp);
            else n_pass++;
            n_checks++;
            if (busy !== e_busy) $display("FAIL term_busy c=%0d got=%b want=%b", c, busy, e_busy);
            else n_pass++;
            n_checks++;
            if (rem !== e_rem) $display("FAIL term_remaining c=%0d got=%0d want=%0d", c, rem, e_rem);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_reset_midwait();
        logic e_exp, e_busy;
        logic [3:0] e_rem;
        begin_scenario();
        for (int c = 0; c <= 40; c++) begin
            start = (c == 10 || c == 20);
            tw    = (c == 10) ? 4'd5 : (c == 20) ? 4'd1 : 4'd0;
            rst_n = !(c == 13 || c == 14);
            #1;
            e_exp  = (c == 25);
            e_busy = (c >= 11 && c <= 12) || (c >= 21 && c <= 24);
            e_rem  = (c >= 11 && c <= 12) ? 4'd5 : (c >= 21 && c <= 24) ? 4'd1 : 4'd0;
            n_checks++;
            if (expired !== e_exp) $display("FAIL rstmid_expired c=%0d got=%b want=%b", c, expired, e_exp);
            else n_pass++;
            n_checks++;
            if (busy !== e_busy) $display("FAIL rstmid_busy c=%0d got=%b want=%b", c, busy, e_busy);
            else n_pass++;
            n_checks++;
            if (rem !== e_rem) $display("FAIL rstmid_remaining c=%0d got=%0d want=%0d", c, rem, e_rem);
            else n_pass++;
            next_cycle();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic e_exp;
        begin_scenario();
        for (int c = 0; c <= 16; c++) begin
            start = (c == 10 || c == 11);
            tw    = 4'd0;
            #1;
            e_exp = (c == 11 || c == 12);
            n_checks++;
            if (expired !== e_exp) $display("FAIL b2b_expired c=%0d got=%b want=%b", c, expired, e_exp);
            else n_pass++;
            n_checks++;
            if (busy !== 1'b0) $display("FAIL b2b_busy c=%0d got=%b want=0", c, busy);
            else n_pass++;
            next_cycle();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        tw    = 4'd0;
        pause = 1'b0;
        test_reset();
        test_basic_w3();
        test_zero_wait();
        test_pause();
        test_restart();
        test_start_at_terminal();
        test_reset_midwait();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
